// File: rtl/icache_dm_pkg.sv
// Bus types shared by the fetch-side ibus and the memory-side cbus of icache_dm.
package icache_dm_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits from flop arrays,
// misses refilled with one INCR burst on the cbus.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  ibus_req_t     ireq,
  output ibus_resp_t    iresp,
  output cbus_req_t     creq,
  input  cbus_resp_t    cresp,
  input  logic          inv,
  output icache_state_e dbg_state_o
);

  // Handshake: ibus is answered combinationally (addr_ok/data_ok together on a hit);
  // cbus beats are consumed on every cycle where cresp.ready is high while creq.valid=1.
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned BW   = $clog2(LINE_BEATS);
  localparam int unsigned OFS  = BW + 3;
  localparam int unsigned TAGW = 64 - OFS - IDX;
  localparam int unsigned LW   = 64 - OFS;

  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic [BW-1:0]   req_beat;
  logic            req_half;

  assign req_idx  = ireq.addr[OFS+IDX-1:OFS];
  assign req_tag  = ireq.addr[63:OFS+IDX];
  assign req_beat = ireq.addr[OFS-1:3];
  assign req_half = ireq.addr[2];

  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [63:0]     data_q [SETS][LINE_BEATS];
  logic [LW-1:0]   line_q;
  logic [BW-1:0]   cnt_q;
  logic            kill_q;
  icache_state_e   state_q;
  cbus_req_t       creq_q;

  logic [IDX-1:0]  lidx;
  logic [TAGW-1:0] ltag;
  logic            hit;
  logic [63:0]     hit_word;
  logic            beat_fire;
  logic            last_fire;
  logic            unused_addr_bits;

  assign lidx = line_q[IDX-1:0];
  assign ltag = line_q[LW-1:IDX];

  assign hit       = (state_q == ST_IDLE) & ireq.valid & valid_q[req_idx]
                   & (tag_q[req_idx] == req_tag) & ~inv;
  assign hit_word  = data_q[req_idx][req_beat];
  assign beat_fire = (state_q == ST_REFILL) & cresp.ready & ~reset;
  assign last_fire = beat_fire & cresp.last;

  assign unused_addr_bits = ^ireq.addr[1:0];

  always_comb begin
    iresp = '0;
    if (hit) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = req_half ? hit_word[63:32] : hit_word[31:0];
    end
  end

  // Tag and data arrays carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      data_q[lidx][cnt_q] <= cresp.data;
    end
    if (last_fire & ~kill_q & ~inv) begin
      tag_q[lidx] <= ltag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      line_q  <= '0;
      creq_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inv) begin
            valid_q <= '0;
          end else if (ireq.valid && !hit) begin
            state_q         <= ST_REFILL;
            line_q          <= ireq.addr[63:OFS];
            cnt_q           <= '0;
            creq_q.valid    <= 1'b1;
            creq_q.is_write <= 1'b0;
            creq_q.size     <= MSIZE8;
            creq_q.addr     <= {ireq.addr[63:OFS], {OFS{1'b0}}};
            creq_q.strobe   <= '0;
            creq_q.data     <= '0;
            creq_q.len      <= 8'(LINE_BEATS - 1);
            creq_q.burst    <= AXI_BURST_INCR;
          end
        end
        ST_REFILL: begin
          if (inv) begin
            valid_q <= '0;
            kill_q  <= 1'b1;
          end
          if (cresp.ready) begin
            cnt_q <= cnt_q + 1'b1;
            // An invalidate on the final beat also kills the line being filled.
            if (cresp.last) begin
              if (!kill_q && !inv) begin
                valid_q[lidx] <= 1'b1;
              end
              kill_q  <= 1'b0;
              state_q <= ST_IDLE;
              creq_q  <= '0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign creq        = creq_q;
  assign dbg_state_o = state_q;

endmodule
